// File: rtl/fifo_tx_drainer.sv
// -----------------------------------------------------------------------------
// fifo_tx_drainer
//
// Read-side consumer for the async FIFO, running in the FIFO read clock domain.
// Pops one word at a time when the FIFO is non-empty and the serial transmitter
// is idle. Each popped word is presented to the transmitter with a one-cycle
// valid strobe. The block then follows TX_BUSY so that the next pop waits until
// the current word has been fully sent.
//
// Handshake: a word is offered by a single-cycle TX_VALID pulse with TX_DATA
// stable. The transmitter acknowledges by raising TX_BUSY. The word is complete
// when TX_BUSY falls. There is no ready/backpressure; if TX_BUSY does not rise
// within ACK_TIMEOUT cycles of the offer, the word is dropped and TIMEOUT_ERR
// sets.
//
// Ports
//   CLK           read-domain clock (same as FIFO R_CLK)
//   RST           asynchronous, active-high reset
//   ENABLE        1 = allow new pops; 0 = finish current word, then hold
//   FIFO_EMPTY    FIFO EMPTY flag
//   FIFO_RD_DATA  FIFO head word (valid while !FIFO_EMPTY)
//   FIFO_R_INC    one-cycle pop strobe to FIFO
//   TX_BUSY       transmitter busy
//   TX_DATA       registered word to transmitter
//   TX_VALID      one-cycle strobe, TX_DATA valid
//   SENT_CNT      words acknowledged by TX (wraps)
//   TIMEOUT_ERR   sticky ack-timeout flag, cleared only by RST
//   dbg_state     FSM state: 0=IDLE, 1=ISSUE, 2=WAIT_ACK, 3=WAIT_DONE
// -----------------------------------------------------------------------------
module fifo_tx_drainer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16,   // must be >= 2
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_R_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    output logic [CNT_WIDTH-1:0]  SENT_CNT,
    output logic                  TIMEOUT_ERR,
    output logic [1:0]            dbg_state
);

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    // The counter is cleared in ISSUE and increments once per WAIT_ACK cycle
    // without TX_BUSY. The abort fires on the edge where the counter would
    // reach ACK_TIMEOUT-1. As a result, the FSM is back in IDLE exactly
    // ACK_TIMEOUT cycles after entering ISSUE.
    localparam logic [TW-1:0] TCNT_ABORT = TW'(ACK_TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         tcnt, tcnt_nxt;
    logic [DATA_WIDTH-1:0] tx_data_nxt;
    logic                  tx_valid_nxt;
    logic                  r_inc_nxt;
    logic [CNT_WIDTH-1:0]  sent_nxt;
    logic                  err_nxt;

    assign dbg_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            tcnt        <= '0;
            TX_DATA     <= '0;
            TX_VALID    <= 1'b0;
            FIFO_R_INC  <= 1'b0;
            SENT_CNT    <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_nxt;
            tcnt        <= tcnt_nxt;
            TX_DATA     <= tx_data_nxt;
            TX_VALID    <= tx_valid_nxt;
            FIFO_R_INC  <= r_inc_nxt;
            SENT_CNT    <= sent_nxt;
            TIMEOUT_ERR <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tcnt_nxt     = tcnt;
        tx_data_nxt  = TX_DATA;
        tx_valid_nxt = 1'b0;
        r_inc_nxt    = 1'b0;
        sent_nxt     = SENT_CNT;
        err_nxt      = TIMEOUT_ERR;

        case (state)
            IDLE: begin
                // Capture the head word, and raise both strobes, on the same
                // edge that leaves IDLE. The strobes are then high for
                // exactly the ISSUE cycle.
                if (ENABLE && !FIFO_EMPTY && !TX_BUSY) begin
                    state_nxt    = ISSUE;
                    tx_data_nxt  = FIFO_RD_DATA;
                    tx_valid_nxt = 1'b1;
                    r_inc_nxt    = 1'b1;
                end
            end
            ISSUE: begin
                tcnt_nxt  = '0;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_DONE;
                    sent_nxt  = SENT_CNT + CNT_WIDTH'(1);
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                    // The word has already been popped, so the abort
                    // simply drops it.
                    if (tcnt == TCNT_ABORT) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
